// File: rtl/prom_arbiter.sv
// Two-port arbiter for the single-port boot PROM: picks one read per cycle,
// drives ce/adr, and steers the 1-cycle-latency PROM data back to its owner.
module prom_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic [AW-1:0] p0_adr,
   output logic          p0_ack,
   output logic [DW-1:0] p0_data,
   input  logic          p1_req,
   input  logic [AW-1:0] p1_adr,
   output logic          p1_ack,
   output logic [DW-1:0] p1_data,
   output logic          rom_ce,
   output logic [AW-1:0] rom_adr,
   input  logic [DW-1:0] rom_data
);

   // Handshake: a requester raises pN_req with a stable pN_adr and holds both
   // until the single-cycle pN_ack; req still high in the cycle after ack is a new read.

   logic          pend_vld_q, pend_vld_d;
   logic          pend_port_q, pend_port_d;
   logic          last_grant_q, last_grant_d;
   logic [DW-1:0] hold0_q, hold0_d;
   logic [DW-1:0] hold1_q, hold1_d;

   logic elig0, elig1;
   logic grant, gport, issue;

   always_comb begin
      // The ack cycle still shows the old request, so the owner of the read in flight is masked.
      elig0 = p0_req & ~(pend_vld_q & ~pend_port_q);
      elig1 = p1_req & ~(pend_vld_q &  pend_port_q);
      grant = 1'b0;
      gport = 1'b0;
      if (elig0 && elig1) begin
         grant = 1'b1;
         gport = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
      end else if (elig0) begin
         grant = 1'b1;
         gport = 1'b0;
      end else if (elig1) begin
         grant = 1'b1;
         gport = 1'b1;
      end
      issue   = grant & ~rst;
      rom_ce  = issue;
      rom_adr = '0;
      if (issue) begin
         rom_adr = gport ? p1_adr : p0_adr;
      end
   end

   always_comb begin
      pend_vld_d   = grant;
      pend_port_d  = gport;
      last_grant_d = grant ? gport : last_grant_q;
      // Acks are suppressed under reset so an aborted read never completes.
      p0_ack  = pend_vld_q & ~pend_port_q & ~rst;
      p1_ack  = pend_vld_q &  pend_port_q & ~rst;
      hold0_d = p0_ack ? rom_data : hold0_q;
      hold1_d = p1_ack ? rom_data : hold1_q;
      p0_data = p0_ack ? rom_data : hold0_q;
      p1_data = p1_ack ? rom_data : hold1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q   <= 1'b0;
         pend_port_q  <= 1'b0;
         last_grant_q <= 1'b1;
         hold0_q      <= '0;
         hold1_q      <= '0;
      end else begin
         pend_vld_q   <= pend_vld_d;
         pend_port_q  <= pend_port_d;
         last_grant_q <= last_grant_d;
         hold0_q      <= hold0_d;
         hold1_q      <= hold1_d;
      end
   end

endmodule

// File: tb/tb_prom_arbiter.sv
// Bench for prom_arbiter: round-robin and fixed-priority instances share the
// requester stimulus; each has its own registered PROM model.
module tb_prom_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_req, p1_req;
   logic [AW-1:0] p0_adr, p1_adr;
   logic          p0_ack, p1_ack, rom_ce;
   logic [DW-1:0] p0_data, p1_data, rom_data;
   logic [AW-1:0] rom_adr;
   logic          fp_p0_ack, fp_p1_ack, fp_rom_ce;
   logic [DW-1:0] fp_p0_data, fp_p1_data, fp_rom_data;
   logic [AW-1:0] fp_rom_adr;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp0_q[$];
   logic [DW-1:0] exp1_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prom_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_adr(p0_adr), .p0_ack(p0_ack), .p0_data(p0_data),
      .p1_req(p1_req), .p1_adr(p1_adr), .p1_ack(p1_ack), .p1_data(p1_data),
      .rom_ce(rom_ce), .rom_adr(rom_adr), .rom_data(rom_data)
   );

   prom_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_adr(p0_adr), .p0_ack(fp_p0_ack), .p0_data(fp_p0_data),
      .p1_req(p1_req), .p1_adr(p1_adr), .p1_ack(fp_p1_ack), .p1_data(fp_p1_data),
      .rom_ce(fp_rom_ce), .rom_adr(fp_rom_adr), .rom_data(fp_rom_data)
   );

   always @(posedge clk) begin
      if (rom_ce)    rom_data    <= mem[rom_adr];
      if (fp_rom_ce) fp_rom_data <= mem[fp_rom_adr];
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every ack on the round-robin instance pops one expected word.
   always @(negedge clk) begin
      if (!rst) begin
         if (p0_ack) begin
            if (exp0_q.size() == 0) check("p0_spurious_ack", {31'b0, p0_ack}, 0);
            else check("p0_data", p0_data, exp0_q.pop_front());
         end
         if (p1_ack) begin
            if (exp1_q.size() == 0) check("p1_spurious_ack", {31'b0, p1_ack}, 0);
            else check("p1_data", p1_data, exp1_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      p0_req = 1'b0; p1_req = 1'b0; p0_adr = '0; p1_adr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Issues n back-to-back reads on one port; req stays high across reads.
   task automatic drv(input bit port, input int adr0, input int step, input int n);
      logic [AW-1:0] a;
      bit got;
      int w;
      for (int i = 0; i < n; i++) begin
         a = AW'(adr0 + i * step);
         if (port) begin p1_req = 1'b1; p1_adr = a; exp1_q.push_back(mem[a]); end
         else      begin p0_req = 1'b1; p0_adr = a; exp0_q.push_back(mem[a]); end
         got = 1'b0;
         w = 0;
         while (!got && w < 20) begin
            @(negedge clk);
            got = port ? p1_ack : p0_ack;
            w++;
         end
         if (!got) check("ack_timeout", {31'b0, got}, 1);
         @(posedge clk); #1;
      end
      if (port) p1_req = 1'b0; else p0_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      mem[10'h000] = 32'hE700_0000;
      mem[10'h010] = 32'h0000_1010;
      mem[10'h020] = 32'h1234_5678;
      mem[10'h3FF] = 32'hA5A5_0FF0;

      // Reset values
      do_reset();
      @(negedge clk);
      check("rst_p0_ack", {31'b0, p0_ack}, 0);
      check("rst_p1_ack", {31'b0, p1_ack}, 0);
      check("rst_p0_data", p0_data, 0);
      check("rst_p1_data", p1_data, 0);
      check("rst_rom_ce", {31'b0, rom_ce}, 0);
      @(posedge clk); #1;

      // Single requester: issue every other cycle
      fork
         drv(0, 'h000, 0, 3);
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_ce", {31'b0, rom_ce}, (k % 2 == 0));
            if (k % 2 == 0) check("t1_adr", {22'b0, rom_adr}, 0);
            check("t1_ack", {31'b0, p0_ack}, (k % 2 == 1));
         end
      join

      // Simultaneous first requests after reset: port 0 first
      do_reset();
      fork
         drv(0, 'h010, 0, 1);
         drv(1, 'h3FF, 0, 1);
         begin
            @(negedge clk);
            check("t2_c0_ce", {31'b0, rom_ce}, 1);
            check("t2_c0_adr", {22'b0, rom_adr}, 'h010);
            @(negedge clk);
            check("t2_c1_adr", {22'b0, rom_adr}, 'h3FF);
            check("t2_c1_p0ack", {31'b0, p0_ack}, 1);
            check("t2_c1_p1ack", {31'b0, p1_ack}, 0);
            @(negedge clk);
            check("t2_c2_ce", {31'b0, rom_ce}, 0);
            check("t2_c2_p1ack", {31'b0, p1_ack}, 1);
            check("t2_c2_p0ack", {31'b0, p0_ack}, 0);
         end
      join

      // Both ports continuous: PROM busy every cycle, strict alternation (both modes)
      do_reset();
      fork
         drv(0, 'h100, 1, 4);
         drv(1, 'h200, 1, 4);
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t3_ce", {31'b0, rom_ce}, 1);
            check("t3_adr", {22'b0, rom_adr}, (k % 2 == 0) ? 'h100 + k / 2 : 'h200 + k / 2);
            check("t3_fp_ce", {31'b0, fp_rom_ce}, 1);
            check("t3_fp_adr", {22'b0, fp_rom_adr}, (k % 2 == 0) ? 'h100 + k / 2 : 'h200 + k / 2);
            check("t3_fp_p1ack", {31'b0, fp_p1_ack}, (k >= 2 && k % 2 == 0));
         end
      join

      // Conflict after a port-0 grant: round-robin picks port 1, fixed prio picks port 0
      do_reset();
      drv(0, 'h005, 0, 1);
      @(posedge clk); #1;
      fork
         drv(0, 'h006, 0, 1);
         drv(1, 'h007, 0, 1);
         begin
            @(negedge clk);
            check("t4_rr_adr", {22'b0, rom_adr}, 'h007);
            check("t4_fp_adr", {22'b0, fp_rom_adr}, 'h006);
         end
      join

      // Reset in the cycle after a port-1 issue
      do_reset();
      drv(1, 'h3FF, 0, 1);
      p1_req = 1'b1; p1_adr = 'h010;
      @(negedge clk);
      check("t5_issue_ce", {31'b0, rom_ce}, 1);
      @(posedge clk); #1;
      rst = 1'b1; p1_req = 1'b0; p0_req = 1'b1; p0_adr = 'h003;
      @(negedge clk);
      check("t5_rst_p1ack", {31'b0, p1_ack}, 0);
      check("t5_rst_ce", {31'b0, rom_ce}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_rst_p1data", p1_data, 0);
      check("t5_rst2_ce", {31'b0, rom_ce}, 0);
      check("t5_rst2_p1ack", {31'b0, p1_ack}, 0);
      @(posedge clk); #1;
      rst = 1'b0; p0_req = 1'b0;
      fork
         drv(0, 'h011, 0, 1);
         drv(1, 'h012, 0, 1);
         begin
            @(negedge clk);
            check("t5_post_adr", {22'b0, rom_adr}, 'h011);
         end
      join

      // Hold: data persists, no ack while idle
      do_reset();
      drv(0, 'h020, 0, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t6_hold_data", p0_data, 32'h1234_5678);
         check("t6_hold_ack", {31'b0, p0_ack}, 0);
      end
      @(posedge clk); #1;

      // Address wrap on port 1, back-to-back
      do_reset();
      fork
         drv(1, 'h3FF, 1, 2);
         begin
            @(negedge clk);
            check("t7_c0_adr", {22'b0, rom_adr}, 'h3FF);
            @(negedge clk);
            check("t7_c1_p1ack", {31'b0, p1_ack}, 1);
            check("t7_c1_p0ack", {31'b0, p0_ack}, 0);
            @(negedge clk);
            check("t7_c2_ce", {31'b0, rom_ce}, 1);
            check("t7_c2_adr", {22'b0, rom_adr}, 'h000);
            @(negedge clk);
            check("t7_c3_p1ack", {31'b0, p1_ack}, 1);
            check("t7_c3_p0ack", {31'b0, p0_ack}, 0);
         end
      join

      // Random bursts on both ports
      for (int r = 0; r < 6; r++) begin
         fork
            drv(0, $urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(1, 4));
            drv(1, $urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(1, 4));
         join
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (3) @(posedge clk);
      check("q0_empty", exp0_q.size(), 0);
      check("q1_empty", exp1_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
